biu_arb: RTL and testbench

- Parametrised multi-master, multi-slave bus interface unit. Successor to the two-master/two-slave combinational router.
- Arbitrates NM masters onto NS slaves with a registered grant, a per-transaction request/acknowledge handshake and a selectable arbitration mode (fixed priority or round-robin).
- Adds a per-transaction timeout and decode-error response.
- Sits between the core's master ports (EX at index 0, IF at index 1, optional DMA at index 2) and the ROM/RAM/peripheral slaves.

---
 rtl/biu_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_biu_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/biu_arb.sv
// biu_arb: multi-master / multi-slave bus interface unit.
//
// Arbitrates NM masters onto NS slaves. The grant is registered in IDLE and
// one transfer is carried per BUSY phase. The slave index is the top four
// address bits, and those bits are cleared on the shared slave address. A
// transfer ends in one of four ways: a slave ack, a decode error, a timeout,
// or an abort (the granted master drops its request).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   m_req/m_we           per-master request / write enable      [NM]
//   m_addr               per-master address                     [NM*AW]
//   m_addr_sel           per-master byte lane select            [NM*4]
//   m_wdata / m_rdata    per-master write / read data           [NM*DW]
//   m_ack / m_err        per-master one-cycle completion / error
//   biu_hold_flag        per-master stall (m_req & ~m_ack)
//   s_req                one-hot slave request                  [NS]
//   s_we, s_addr, s_addr_sel, s_wdata  shared slave-side fields
//   s_rdata / s_ack      per-slave read data / completion       [NS*DW]/[NS]
module biu_arb #(
  parameter int NM       = 2,
  parameter int NS       = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*4-1:0]  m_addr_sel,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_err,
  output logic [NM-1:0]    biu_hold_flag,
  output logic [NS-1:0]    s_req,
  output logic             s_we,
  output logic [AW-1:0]    s_addr,
  output logic [3:0]       s_addr_sel,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ack
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r, state_nxt;
  logic [GW-1:0] gnt_r, gnt_nxt;
  logic [GW-1:0] rr_ptr_r, rr_ptr_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;

  // Fields of the currently granted master.
  logic          g_req, g_we;
  logic [AW-1:0] g_addr;
  logic [3:0]    g_sel;
  logic [DW-1:0] g_wdata;
  logic [3:0]    dec;
  logic          dec_ok;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;
  logic          ack_hit, to_hit;

  // Arbitration. In fixed mode the lowest set index wins. In round-robin
  // mode the search starts at ptr+1 and wraps modulo NM.
  function automatic logic [GW-1:0] pick_fn(input logic [NM-1:0] req,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    if (ARB_MODE == 1) begin
      for (int k = 1; k <= NM; k++) begin
        idx = (int'(ptr) + k) % NM;
        for (int i = 0; i < NM; i++) begin
          if (!found && (i == idx) && req[i]) begin
            r     = GW'(i);
            found = 1'b1;
          end else begin
            r = r;
          end
        end
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (req[i]) begin
          r = GW'(i);
        end else begin
          r = r;
        end
      end
    end
    return r;
  endfunction

  // Mux the granted master's request fields.
  always_comb begin
    g_req   = 1'b0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_sel   = 4'd0;
    g_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (GW'(i) == gnt_r) begin
        g_req   = m_req[i];
        g_we    = m_we[i];
        g_addr  = m_addr[i*AW +: AW];
        g_sel   = m_addr_sel[i*4 +: 4];
        g_wdata = m_wdata[i*DW +: DW];
      end else begin
        g_req = g_req;
      end
    end
  end

  assign dec    = g_addr[AW-1 -: 4];
  assign dec_ok = ({28'd0, dec} < 32'(NS));

  // Select ack / read data of the decoded slave only; other acks are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (4'(i) == dec) begin
        sel_ack   = s_ack[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end else begin
        sel_ack = sel_ack;
      end
    end
  end

  assign ack_hit = (state_r == BUSY) && g_req && dec_ok && sel_ack;
  // An ack in the expiry cycle wins over the timeout.
  assign to_hit  = (state_r == BUSY) && g_req && dec_ok && !sel_ack &&
                   (cnt_r == CW'(TIMEOUT - 1));

  // State register with grant, round-robin pointer and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      gnt_r    <= '0;
      rr_ptr_r <= GW'(NM - 1);
      cnt_r    <= '0;
    end else begin
      state_r  <= state_nxt;
      gnt_r    <= gnt_nxt;
      rr_ptr_r <= rr_ptr_nxt;
      cnt_r    <= cnt_nxt;
    end
  end

  // Next-state logic. The counter is cleared on every exit from BUSY.
  always_comb begin
    state_nxt  = state_r;
    gnt_nxt    = gnt_r;
    rr_ptr_nxt = rr_ptr_r;
    cnt_nxt    = '0;
    case (state_r)
      IDLE: begin
        if (|m_req) begin
          state_nxt = BUSY;
          gnt_nxt   = pick_fn(m_req, rr_ptr_r);
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (!g_req) begin
          // Abort: the pointer is left alone.
          state_nxt = IDLE;
        end else if (!dec_ok || ack_hit || to_hit) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = gnt_r;
        end else begin
          state_nxt = BUSY;
          cnt_nxt   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. Everything is zero outside an active BUSY transfer.
  always_comb begin
    s_req      = '0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_addr_sel = 4'd0;
    s_wdata    = '0;
    m_ack      = '0;
    m_err      = '0;
    m_rdata    = '0;
    if ((state_r == BUSY) && g_req) begin
      if (dec_ok) begin
        for (int i = 0; i < NS; i++) begin
          s_req[i] = (4'(i) == dec);
        end
        s_we       = g_we;
        s_addr     = {4'd0, g_addr[AW-5:0]};
        s_addr_sel = g_sel;
        s_wdata    = g_wdata;
      end else begin
        s_req = '0;
      end
      for (int i = 0; i < NM; i++) begin
        if (GW'(i) == gnt_r) begin
          m_ack[i]             = ack_hit;
          m_err[i]             = !dec_ok || to_hit;
          m_rdata[i*DW +: DW]  = ack_hit ? sel_rdata : '0;
        end else begin
          m_ack[i] = 1'b0;
        end
      end
    end else begin
      s_req = '0;
    end
  end

  assign biu_hold_flag = m_req & ~m_ack;

endmodule

// File: tb/tb_biu_arb.sv
// Directed testbench for biu_arb. Instance A is NM=2, NS=2, TIMEOUT=4 in
// fixed mode, with slave acks driven by hand. Instance B is NM=3,
// round-robin, and its slaves ack in the same cycle as the request.
module tb_biu_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A signals.
  logic        rst_a;
  logic [1:0]  a_m_req, a_m_we, a_m_ack, a_m_err, a_hold;
  logic [63:0] a_m_addr, a_m_wdata, a_m_rdata;
  logic [7:0]  a_m_sel;
  logic [1:0]  a_s_req, a_s_ack;
  logic        a_s_we;
  logic [31:0] a_s_addr, a_s_wdata;
  logic [3:0]  a_s_sel;
  logic [63:0] a_s_rdata;

  // Instance B signals.
  logic        rst_b;
  logic [2:0]  b_m_req, b_m_we, b_m_ack, b_m_err, b_hold;
  logic [95:0] b_m_addr, b_m_wdata, b_m_rdata;
  logic [11:0] b_m_sel;
  logic [1:0]  b_s_req, b_s_ack;
  logic        b_s_we;
  logic [31:0] b_s_addr, b_s_wdata;
  logic [3:0]  b_s_sel;
  logic [63:0] b_s_rdata;

  assign b_s_ack = b_s_req;

  biu_arb #(.NM(2), .NS(2), .AW(32), .DW(32), .ARB_MODE(0), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst_a),
    .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr), .m_addr_sel(a_m_sel),
    .m_wdata(a_m_wdata), .m_rdata(a_m_rdata), .m_ack(a_m_ack), .m_err(a_m_err),
    .biu_hold_flag(a_hold), .s_req(a_s_req), .s_we(a_s_we), .s_addr(a_s_addr),
    .s_addr_sel(a_s_sel), .s_wdata(a_s_wdata), .s_rdata(a_s_rdata), .s_ack(a_s_ack)
  );

  biu_arb #(.NM(3), .NS(2), .AW(32), .DW(32), .ARB_MODE(1), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst_b),
    .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_addr_sel(b_m_sel),
    .m_wdata(b_m_wdata), .m_rdata(b_m_rdata), .m_ack(b_m_ack), .m_err(b_m_err),
    .biu_hold_flag(b_hold), .s_req(b_s_req), .s_we(b_s_we), .s_addr(b_s_addr),
    .s_addr_sel(b_s_sel), .s_wdata(b_s_wdata), .s_rdata(b_s_rdata), .s_ack(b_s_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  logic [2:0] exp_ack [8];

  initial begin
    exp_ack[0] = 3'b000; exp_ack[1] = 3'b001; exp_ack[2] = 3'b000; exp_ack[3] = 3'b010;
    exp_ack[4] = 3'b000; exp_ack[5] = 3'b100; exp_ack[6] = 3'b000; exp_ack[7] = 3'b001;

    rst_a = 1'b1; rst_b = 1'b1;
    a_m_req = 2'b00; a_m_we = 2'b00; a_m_sel = 8'hFF; a_m_wdata = 64'h1111_2222_3333_4444;
    a_m_addr = {32'h0000_0020, 32'h1000_0010};
    a_s_rdata = {32'hCAFE_0001, 32'h0000_1234}; a_s_ack = 2'b00;
    b_m_req = 3'b000; b_m_we = 3'b000; b_m_sel = 12'hFFF; b_m_wdata = 96'd0;
    b_m_addr = {32'h0000_0300, 32'h1000_0200, 32'h0000_0100};
    b_s_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
    step; step;
    rst_a = 1'b0; rst_b = 1'b0;
    settle;

    // Reset state
    check("rst_s_req",   64'(a_s_req),   64'd0);
    check("rst_s_addr",  64'(a_s_addr),  64'd0);
    check("rst_s_we",    64'(a_s_we),    64'd0);
    check("rst_m_ack",   64'(a_m_ack),   64'd0);
    check("rst_m_err",   64'(a_m_err),   64'd0);
    check("rst_m_rdata", a_m_rdata,      64'd0);
    check("rst_hold",    64'(a_hold),    64'd0);

    // Fixed priority, both masters requesting
    a_m_req = 2'b11; settle;
    check("t1_idle_s_req", 64'(a_s_req), 64'd0);
    check("t1_idle_hold",  64'(a_hold),  64'h3);
    step; settle;
    check("t1_b1_s_req",  64'(a_s_req),  64'h2);
    check("t1_b1_s_addr", 64'(a_s_addr), 64'h0000_0010);
    check("t1_b1_m_ack",  64'(a_m_ack),  64'd0);
    step;
    a_s_ack = 2'b10; settle;
    check("t1_b2_m_ack",   64'(a_m_ack),        64'h1);
    check("t1_b2_rdata0",  64'(a_m_rdata[31:0]),  64'hCAFE_0001);
    check("t1_b2_rdata1",  64'(a_m_rdata[63:32]), 64'd0);
    check("t1_b2_hold",    64'(a_hold),         64'h2);
    step;
    a_m_req = 2'b10; a_s_ack = 2'b00; settle;
    check("t1_idle2_s_req", 64'(a_s_req), 64'd0);
    check("t1_idle2_hold",  64'(a_hold),  64'h2);
    step; settle;
    check("t1_m1_s_req",  64'(a_s_req),  64'h1);
    check("t1_m1_s_addr", 64'(a_s_addr), 64'h0000_0020);
    a_s_ack = 2'b01; settle;
    check("t1_m1_m_ack",  64'(a_m_ack),           64'h2);
    check("t1_m1_rdata1", 64'(a_m_rdata[63:32]),  64'h0000_1234);
    check("t1_m1_hold",   64'(a_hold),            64'd0);
    step;
    a_m_req = 2'b00; a_s_ack = 2'b00;
    step;

    // Decode error
    a_m_we = 2'b01; a_m_addr[31:0] = 32'h5000_0000; a_m_req = 2'b01;
    step; settle;
    check("t3_s_req", 64'(a_s_req), 64'd0);
    check("t3_m_err", 64'(a_m_err), 64'h1);
    check("t3_m_ack", 64'(a_m_ack), 64'd0);
    step; settle;
    check("t3_idle_m_err", 64'(a_m_err), 64'd0);
    check("t3_idle_s_req", 64'(a_s_req), 64'd0);
    step;
    a_m_req = 2'b00; a_m_we = 2'b00;
    step;

    // Timeout after four BUSY cycles
    a_m_addr[31:0] = 32'h1000_0004; a_m_req = 2'b01;
    step;
    for (int c = 1; c <= 4; c++) begin
      settle;
      check("t4_s_req", 64'(a_s_req), 64'h2);
      check("t4_m_err", 64'(a_m_err), (c == 4) ? 64'h1 : 64'h0);
      step;
    end
    a_m_req = 2'b00; settle;
    check("t4_after_s_req", 64'(a_s_req), 64'd0);
    check("t4_after_m_err", 64'(a_m_err), 64'd0);
    step;

    // Ack coincident with the timeout cycle
    a_m_req = 2'b01;
    step;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) a_s_ack = 2'b10;
      settle;
      check("t6_m_ack", 64'(a_m_ack), (c == 4) ? 64'h1 : 64'h0);
      check("t6_m_err", 64'(a_m_err), 64'd0);
      step;
    end
    a_m_req = 2'b00; a_s_ack = 2'b00;
    step;

    // Abort in the second BUSY cycle
    a_m_addr[31:0] = 32'h1000_0000; a_m_req = 2'b01;
    step; settle;
    check("t5a_b1_s_req", 64'(a_s_req), 64'h2);
    step;
    a_m_req = 2'b00; settle;
    check("t5a_s_req", 64'(a_s_req), 64'd0);
    check("t5a_m_ack", 64'(a_m_ack), 64'd0);
    check("t5a_m_err", 64'(a_m_err), 64'd0);
    step; settle;
    check("t5a_idle_s_req", 64'(a_s_req), 64'd0);
    check("t5a_idle_m_err", 64'(a_m_err), 64'd0);

    // Reset mid-BUSY
    a_m_req = 2'b01;
    step; settle;
    check("t5b_b1_s_req", 64'(a_s_req), 64'h2);
    rst_a = 1'b1;
    step;
    rst_a = 1'b0; settle;
    check("t5b_s_req",   64'(a_s_req),  64'd0);
    check("t5b_s_addr",  64'(a_s_addr), 64'd0);
    check("t5b_m_ack",   64'(a_m_ack),  64'd0);
    check("t5b_m_err",   64'(a_m_err),  64'd0);
    check("t5b_m_rdata", a_m_rdata,     64'd0);
    step;
    a_m_req = 2'b00;
    step;

    // Round-robin, three masters requesting continuously, immediate ack
    b_m_req = 3'b111;
    for (int c = 0; c < 8; c++) begin
      settle;
      check("t2_rr_ack", 64'(b_m_ack), 64'(exp_ack[c]));
      step;
    end
    settle;
    check("t2_c8_ack", 64'(b_m_ack), 64'd0);
    step; settle;
    check("t2_c9_ack",    64'(b_m_ack),          64'h2);
    check("t2_c9_s_req",  64'(b_s_req),          64'h2);
    check("t2_c9_rdata1", 64'(b_m_rdata[63:32]), 64'hBBBB_0001);
    rst_b = 1'b1;
    step;
    rst_b = 1'b0; settle;
    check("t2_rst_ack",   64'(b_m_ack), 64'd0);
    check("t2_rst_s_req", 64'(b_s_req), 64'd0);
    step; settle;
    // rr_ptr returns to NM-1 on reset, so master 0 wins next.
    check("t2_rst_rr_gnt", 64'(b_m_ack), 64'h1);
    step;
    b_m_req = 3'b000;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
